// File: rtl/ctrl_pkg.sv
// Shared definitions for the control FSM: state encoding, instruction bit
// indices of the one-hot decode bus, exception codes and instruction classes.
package ctrl_pkg;

  localparam int NUM_INSTR = 55;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_MDWAIT = 3'd5,
    ST_EXC    = 3'd6
  } state_e;

  localparam logic [2:0] EXC_SYSCALL = 3'd0;
  localparam logic [2:0] EXC_BREAK   = 3'd1;
  localparam logic [2:0] EXC_TRAP    = 3'd2;
  localparam logic [2:0] EXC_ILLEGAL = 3'd3;
  localparam logic [2:0] EXC_TIMEOUT = 3'd4;

  typedef enum logic [3:0] {
    CLS_NONE, CLS_ALU, CLS_BRANCH, CLS_LINK, CLS_LOAD, CLS_STORE,
    CLS_MULDIV, CLS_MOVETO, CLS_SYSCALL, CLS_BREAK, CLS_TRAP
  } cls_e;

  // Bit positions on the one-hot instruction bus
  localparam int I_ADD = 0,  I_ADDU = 1,  I_SUB = 2,   I_SUBU = 3,  I_AND = 4;
  localparam int I_OR = 5,   I_XOR = 6,   I_NOR = 7,   I_SLT = 8,   I_SLTU = 9;
  localparam int I_ADDI = 10, I_ADDIU = 11, I_ANDI = 12, I_ORI = 13, I_XORI = 14;
  localparam int I_LUI = 15, I_SLTI = 16, I_SLTIU = 17, I_SLL = 18, I_SRL = 19;
  localparam int I_SRA = 20, I_SLLV = 21, I_SRLV = 22, I_SRAV = 23;
  localparam int I_SW = 24,  I_SB = 25,   I_SH = 26;
  localparam int I_LW = 27,  I_LB = 28,   I_LBU = 29,  I_LH = 30,   I_LHU = 31;
  localparam int I_BEQ = 32, I_BNE = 33,  I_BGEZ = 34, I_J = 35,    I_JAL = 36;
  localparam int I_JR = 37,  I_JALR = 38;
  localparam int I_MULT = 39, I_MULTU = 40, I_DIV = 41, I_DIVU = 42;
  localparam int I_MFHI = 43, I_MFLO = 44, I_MTHI = 45, I_MTLO = 46;
  localparam int I_MFC0 = 47, I_MTC0 = 48, I_ERET = 49;
  localparam int I_SYSCALL = 50, I_BREAK = 51, I_TEQ = 52, I_CLZ = 53, I_MUL = 54;

  function automatic logic [NUM_INSTR-1:0] bit_of(input int idx);
    bit_of = '0;
    bit_of[idx] = 1'b1;
  endfunction

  // Class masks; anything legal that matches none of them is an ALU-type op
  localparam logic [NUM_INSTR-1:0] M_BRANCH = bit_of(I_J) | bit_of(I_JR) | bit_of(I_BEQ) |
                                              bit_of(I_BNE) | bit_of(I_BGEZ) | bit_of(I_ERET);
  localparam logic [NUM_INSTR-1:0] M_LINK   = bit_of(I_JAL) | bit_of(I_JALR);
  localparam logic [NUM_INSTR-1:0] M_LOAD   = bit_of(I_LW) | bit_of(I_LB) | bit_of(I_LBU) |
                                              bit_of(I_LH) | bit_of(I_LHU);
  localparam logic [NUM_INSTR-1:0] M_STORE  = bit_of(I_SW) | bit_of(I_SB) | bit_of(I_SH);
  localparam logic [NUM_INSTR-1:0] M_MULDIV = bit_of(I_MULT) | bit_of(I_MULTU) |
                                              bit_of(I_DIV) | bit_of(I_DIVU);
  localparam logic [NUM_INSTR-1:0] M_MOVETO = bit_of(I_MTHI) | bit_of(I_MTLO) | bit_of(I_MTC0);

endpackage

// File: rtl/ctrl_instr_class.sv
// Combinational instruction classifier: maps the one-hot decode bus to an
// instruction class and flags buses that are not exactly one-hot.
module ctrl_instr_class
  import ctrl_pkg::*;
(
  input  logic [NUM_INSTR-1:0] instr_i,
  output cls_e                 cls_o,
  output logic                 illegal_o
);

  logic legal;

  // Exactly one bit set is legal; an X/Z bus makes 'legal' unknown, which
  // the FSM treats as illegal because it only advances on a known-good flag.
  always_comb begin
    cls_o = CLS_NONE;
    legal = (instr_i != '0) && ((instr_i & (instr_i - 55'd1)) == '0);
    if (legal) begin
      if      (|(instr_i & M_BRANCH))       cls_o = CLS_BRANCH;
      else if (|(instr_i & M_LINK))         cls_o = CLS_LINK;
      else if (|(instr_i & M_LOAD))         cls_o = CLS_LOAD;
      else if (|(instr_i & M_STORE))        cls_o = CLS_STORE;
      else if (|(instr_i & M_MULDIV))       cls_o = CLS_MULDIV;
      else if (|(instr_i & M_MOVETO))       cls_o = CLS_MOVETO;
      else if (instr_i[I_SYSCALL])          cls_o = CLS_SYSCALL;
      else if (instr_i[I_BREAK])            cls_o = CLS_BREAK;
      else if (instr_i[I_TEQ])              cls_o = CLS_TRAP;
      else                                  cls_o = CLS_ALU;
    end
    illegal_o = !legal;
  end

endmodule

// File: rtl/ctrl_fsm.sv
// Multicycle CPU control FSM. Define CTRL_MEM_TIMEOUT_EN to add a bounded
// wait on mem_ready in FETCH/MEM that raises a timeout exception (code 4).
module ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_INSTR-1:0] instr_onehot,
  input  logic                 mem_ready,
  input  logic                 md_done,
  input  logic                 cmp_eq,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic                 rf_we,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 md_start,
  output logic                 exc_req,
  output logic [2:0]           exc_code,
  output logic [2:0]           state
);

  state_e     state_q, state_d;
  cls_e       cls_q, cls_d;
  logic [2:0] exc_code_q, exc_code_d;
  cls_e       cls_w;
  logic       illegal_w;

  ctrl_instr_class u_class (
    .instr_i   (instr_onehot),
    .cls_o     (cls_w),
    .illegal_o (illegal_w)
  );

`ifdef CTRL_MEM_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);
  logic [7:0] wait_q, wait_d;
  logic       timeout_hit;

  // Timeout fires on the cycle whose idle wait would make the count reach
  // MEM_TIMEOUT; a mem_ready on that same cycle wins.
  assign timeout_hit = !mem_ready && (wait_q == WAIT_LAST);

  // Wait counter: cleared on any state change, counts idle memory cycles, saturates
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if ((state_q == ST_FETCH || state_q == ST_MEM) && !mem_ready && wait_q != 8'hFF) begin
      wait_d = wait_q + 8'd1;
    end
  end

  // Wait counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_q <= '0;
    else        wait_q <= wait_d;
  end
`endif

  // Next state, latched class/exception code, and datapath strobes
  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    exc_code_d = exc_code_q;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    rf_we      = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    md_start   = 1'b0;
    exc_req    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = ST_DECODE;
        end
`ifdef CTRL_MEM_TIMEOUT_EN
        else if (timeout_hit) begin
          state_d    = ST_EXC;
          exc_code_d = EXC_TIMEOUT;
        end
`endif
      end
      ST_DECODE: begin
        cls_d = cls_w;
        if (!illegal_w) begin
          state_d = ST_EXEC;
        end else begin
          state_d    = ST_EXC;
          exc_code_d = EXC_ILLEGAL;
        end
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_BRANCH: begin pc_we = 1'b1; state_d = ST_FETCH; end
          CLS_LINK:   begin pc_we = 1'b1; state_d = ST_WB; end
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          CLS_MULDIV: begin md_start = 1'b1; state_d = ST_MDWAIT; end
          CLS_MOVETO: state_d = ST_FETCH;
          CLS_SYSCALL: begin state_d = ST_EXC; exc_code_d = EXC_SYSCALL; end
          CLS_BREAK:   begin state_d = ST_EXC; exc_code_d = EXC_BREAK; end
          CLS_TRAP: begin
            if (cmp_eq) begin
              state_d    = ST_EXC;
              exc_code_d = EXC_TRAP;
            end else begin
              state_d = ST_FETCH;
            end
          end
          default: state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (cls_q == CLS_STORE);
        if (mem_ready) begin
          state_d = (cls_q == CLS_STORE) ? ST_FETCH : ST_WB;
        end
`ifdef CTRL_MEM_TIMEOUT_EN
        else if (timeout_hit) begin
          state_d    = ST_EXC;
          exc_code_d = EXC_TIMEOUT;
        end
`endif
      end
      ST_WB: begin
        rf_we   = 1'b1;
        state_d = ST_FETCH;
      end
      ST_MDWAIT: begin
        if (md_done) state_d = ST_FETCH;
      end
      ST_EXC: begin
        exc_req = 1'b1;
        pc_we   = 1'b1;
        state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
    // Reset is asynchronous, so strobes must drop the moment rst_n falls
    if (!rst_n) begin
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      rf_we    = 1'b0;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      md_start = 1'b0;
      exc_req  = 1'b0;
    end
  end

  // State, latched class and exception code registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FETCH;
      cls_q      <= CLS_NONE;
      exc_code_q <= EXC_SYSCALL;
    end else begin
      state_q    <= state_d;
      cls_q      <= cls_d;
      exc_code_q <= exc_code_d;
    end
  end

  assign state    = state_q;
  assign exc_code = exc_code_q;

endmodule
